// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register, MSB first, valid/ready load, back-to-back words.
// Define FREDKIN_MUX_EN to build the per-bit load/shift and idle-clear selects from fredkin gates.
`ifdef FREDKIN_MUX_EN
module fredkin (
    input  logic c,
    input  logic a,
    input  logic b,
    output logic p,
    output logic q,
    output logic r
);
    assign p = c;
    assign q = c ? b : a;
    assign r = c ? a : b;
endmodule
`endif

module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, sr_n, shifted, loaded;
    logic [CW-1:0] cnt, cnt_n;
    logic last, load, clear;
    assign last = cnt == '0;
    assign load_ready = !rst && (state == IDLE || last);
    assign load = load_valid && load_ready;
    // cnt is 0 throughout IDLE, so clearing there is harmless and keeps sr at 0
    assign clear = last && !load;
    assign shifted = {sr[WIDTH-2:0], 1'b0};
`ifdef FREDKIN_MUX_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_fk
        fredkin u_ld (.c(load), .a(shifted[g]), .b(din[g]), .p(), .q(loaded[g]), .r());
        fredkin u_clr (.c(clear), .a(loaded[g]), .b(1'b0), .p(), .q(sr_n[g]), .r());
    end
`else
    assign loaded = load ? din : shifted;
    assign sr_n = clear ? '0 : loaded;
`endif
    always_comb begin
        state_n = load ? SHIFT : (last ? IDLE : state);
        cnt_n = load ? CW'(WIDTH - 1) : (last ? cnt : cnt - CW'(1));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            cnt <= cnt_n;
        end
    end
    assign busy = state == SHIFT;
    assign so_valid = busy;
    assign so = busy && sr[WIDTH-1];
    assign done = busy && last;
endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in serial-out shift register: the transmit-side counterpart of the team's serial-in serial-out reversible shift register. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `so`, MSB first. Its output drives the `si` input of the downstream serial chain. All storage is DFFs on the single clock `clk`, with no ripple-clocked stages. The load/shift selection per bit is optionally built from Fredkin gates.

## Interface
- `WIDTH`, default 4: word length in bits; legal values are 2 to 32.
- `clk`  input  1: clock; all flops update on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `din`  input  WIDTH: parallel word to transmit.
- `load_valid`  input  1: `din` is valid this cycle.
- `load_ready`  output  1: block can accept a word this cycle.
- `so`  output  1: serial data out, MSB first.
- `so_valid`  output  1: `so` carries a data bit this cycle.
- `busy`  output  1: a word is being shifted out.
- `done`  output  1: one-cycle pulse that coincides with the last bit of a word.

## Operation
- Internal state:
  - `sr[WIDTH-1:0]`: shift register.
  - `cnt[$clog2(WIDTH)-1:0]`: bits remaining minus 1.
  - State bit: IDLE or SHIFT.
- Accept condition: `load_valid && load_ready` on a rising edge.
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `cnt == 0` (last bit).
  - 0 otherwise.
  - Forced to 0 while `rst` is high.
- IDLE:
  - On accept: `sr <= din`, `cnt <= WIDTH-1`, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - Each cycle `sr <= {sr[WIDTH-2:0],1'b0}`.
  - When `cnt != 0`: `cnt <= cnt-1`.
  - When `cnt == 0` with an accept: reload `sr <= din`, `cnt <= WIDTH-1`, stay in SHIFT. This gives back-to-back words with no gap bit.
  - When `cnt == 0` without an accept: go to IDLE, `sr <= 0`.
- Outputs:
  - `so = sr[WIDTH-1]` in SHIFT; 0 in IDLE.
  - `so_valid = busy = (state == SHIFT)`.
  - `done = (state == SHIFT) && (cnt == 0)`.
- `load_valid` while `load_ready` is 0 is ignored. `din` is not sampled and the word in flight is unaffected.
- `din` is sampled only on an accept edge. After that it may change freely.

## Timing
- Reset values: state IDLE, `sr = 0`, `cnt = 0`, `so = 0`, `so_valid = 0`, `busy = 0`, `done = 0`. `load_ready` reads 0 during reset and 1 in the first cycle after release.
- Reset mid-word: the word is aborted immediately (asynchronously). No `done` pulse is produced and no residual bits are emitted after release.
- Latency: the MSB appears on `so` in the cycle after the accept edge. Bit `i` (counting from the MSB at 0) appears `i+1` cycles after accept.
- Word duration: exactly WIDTH cycles of `so_valid`.
- Throughput: one word per WIDTH cycles when `load_valid` is held high.
- `done` is high during the cycle carrying the LSB, one cycle wide per word. During back-to-back operation `done` and `load_ready` are high in the same cycle.

## Configuration
- `FREDKIN_MUX_EN`, defined:
  - The per-bit next-state select (load `din[i]` vs. shift `sr[i-1]`) is built from one `fredkin` instance per bit.
  - The instance is wired as control = load, a = shift bit, b = `din[i]`; the selected bit is taken from output `q`.
  - Outputs `p` and `r` are garbage and left unused.
  - The idle-clear select uses a second `fredkin` instance per bit with a constant-0 input.
- `FREDKIN_MUX_EN`, undefined: the same selects are behavioural conditional assignments.
- Cycle behaviour of all ports is bit-identical in both builds.

## Test plan
- Reset check: assert `rst` for 3 cycles mid-stream. All outputs go to their reset values asynchronously before the next edge. `load_ready` = 1 one cycle after release.
- Single word, WIDTH = 4: accept `din` = 4'b1011. Then:
  - `so` = 1,0,1,1 on cycles +1..+4.
  - `so_valid` is high exactly for those 4 cycles.
  - `done` is high only on cycle +4.
  - `so` = 0 on cycle +5.
- Back-to-back: hold `load_valid` with 4'b1011 then 4'b0110, the second presented in the `done` cycle. `so` = 1,0,1,1,0,1,1,0 with no gap. `done` is high on cycles +4 and +8.
- Busy rejection: accept 4'b1000, then present 4'b1111 with `load_valid` on cycles +1..+2. `so` = 1,0,0,0 and the second word is not transmitted.
- Reset mid-word: accept 4'b1111 and assert `rst` during bit 2. After release, `so` = 0, `busy` = 0, and no `done` pulse occurs.
- Build equivalence: run all of the above with and without `FREDKIN_MUX_EN` and with WIDTH = 8 (word 8'hA5, `so` = 1,0,1,0,0,1,0,1). Waveforms must match cycle for cycle.
